ps2_key_decoder: RTL and testbench

Upstream stage of the player block. Receives raw PS/2 keyboard frames on ps2_clk/ps2_data and strips the F0 (break) and E0 (extended) prefixes. Emits one single-cycle key event per completed scan code, carrying code, break flag and extended flag. The player block consumes these events for cursor movement and placement instead of parsing the PS/2 line itself.

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_frame_rx.sv | 130 +++++++++++++
 rtl/ps2_key_decoder.sv | 93 +++++++++
 tb/tb_ps2_key_decoder.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Brief    : Shared constants, state encoding and parity helper for the PS/2
//            keyboard receive path.
// Revision : 1.0
// ============================================================================
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
    localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;
    localparam int         PS2_FRAME_LEN  = 11;

    typedef logic [1:0] ps2_state_t;

    localparam ps2_state_t ST_IDLE   = 2'd0;
    localparam ps2_state_t ST_DATA   = 2'd1;
    localparam ps2_state_t ST_PARITY = 2'd2;
    localparam ps2_state_t ST_STOP   = 2'd3;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_frame_rx
// Brief    : Synchronises the raw PS/2 lines and deframes 11-bit frames into
//            bytes. Define PS2_PARITY_CHECK_EN to reject bad-parity frames.
// Revision : 1.0
// ============================================================================
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_err,
    output logic       busy
);

    localparam int                c_TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TO_W-1:0] c_TO_ONE  = c_TO_W'(1);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_clk_prev;
    logic                   w_fe;
    logic                   w_data;

    ps2_state_t             r_state;
    ps2_state_t             w_state_nxt;
    logic [2:0]             r_bitcnt;
    logic [7:0]             r_shift;
    logic [c_TO_W-1:0]      r_to_cnt;

    logic                   w_timeout;
    logic                   w_stop_fe;
    logic                   w_par_ok;
    logic                   w_frame_ok;

    // Synchronisers idle high so reset does not fabricate a falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
            r_clk_prev  <= r_clk_sync[SYNC_STAGES-1];
        end
    end

    assign w_fe      = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
    assign w_data    = r_data_sync[SYNC_STAGES-1];
    assign w_timeout = (r_state != ST_IDLE) && !w_fe && (r_to_cnt == c_TO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_fe && !w_data)          w_state_nxt = ST_DATA;
            ST_DATA:   if (w_fe && r_bitcnt == 3'd7) w_state_nxt = ST_PARITY;
            ST_PARITY: if (w_fe)                     w_state_nxt = ST_STOP;
            ST_STOP:   if (w_fe)                     w_state_nxt = ST_IDLE;
            default:                                 w_state_nxt = ST_IDLE;
        endcase
        if (w_timeout) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bitcnt <= 3'd0;
            r_shift  <= 8'd0;
            r_to_cnt <= '0;
        end else begin
            if (r_state == ST_IDLE || w_fe) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + c_TO_ONE;
            end

            if (r_state == ST_IDLE && w_fe) begin
                r_bitcnt <= 3'd0;
            end else if (r_state == ST_DATA && w_fe) begin
                r_shift  <= {w_data, r_shift[7:1]};
                r_bitcnt <= r_bitcnt + 3'd1;
            end
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    logic r_par;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par <= 1'b0;
        end else if (r_state == ST_PARITY && w_fe) begin
            r_par <= w_data;
        end
    end

    assign w_par_ok = odd_parity_ok(r_shift, r_par);
`else
    assign w_par_ok = 1'b1;
`endif

    assign w_stop_fe  = (r_state == ST_STOP) && w_fe;
    assign w_frame_ok = w_data & w_par_ok;

    assign byte_valid = w_stop_fe & w_frame_ok;
    assign byte_err   = (w_stop_fe & ~w_frame_ok) | w_timeout;
    assign byte_data  = r_shift;
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_decoder
// Brief    : Turns PS/2 scan-code bytes into single-cycle key events with
//            break/extended flags. Honours PS2_PARITY_CHECK_EN via ps2_frame_rx.
// Revision : 1.0
// ============================================================================
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_break,
    output logic       key_ext,
    output logic       frame_err,
    output logic       rx_busy
);

    logic       w_byte_valid;
    logic [7:0] w_byte_data;
    logic       w_byte_err;

    logic       r_brk_pend;
    logic       r_ext_pend;
    logic       r_key_valid;
    logic [7:0] r_key_code;
    logic       r_key_break;
    logic       r_key_ext;
    logic       r_frame_err;

    ps2_frame_rx #(
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (w_byte_valid),
        .byte_data  (w_byte_data),
        .byte_err   (w_byte_err),
        .busy       (rx_busy)
    );

    // Prefix bytes only arm flags; the next plain byte consumes them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_brk_pend  <= 1'b0;
            r_ext_pend  <= 1'b0;
            r_key_valid <= 1'b0;
            r_key_code  <= 8'd0;
            r_key_break <= 1'b0;
            r_key_ext   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_byte_err) begin
                r_frame_err <= 1'b1;
                r_brk_pend  <= 1'b0;
                r_ext_pend  <= 1'b0;
            end else if (w_byte_valid) begin
                if (w_byte_data == PS2_BREAK_CODE) begin
                    r_brk_pend <= 1'b1;
                end else if (w_byte_data == PS2_EXT_CODE) begin
                    r_ext_pend <= 1'b1;
                end else begin
                    r_key_valid <= 1'b1;
                    r_key_code  <= w_byte_data;
                    r_key_break <= r_brk_pend;
                    r_key_ext   <= r_ext_pend;
                    r_brk_pend  <= 1'b0;
                    r_ext_pend  <= 1'b0;
                end
            end
        end
    end

    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign key_break = r_key_break;
    assign key_ext   = r_key_ext;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_key_decoder
// Brief    : Self-checking bench for ps2_key_decoder using an event scoreboard.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_ps2_key_decoder;

    localparam int SYNC_STAGES    = 2;
    localparam int TIMEOUT_CYCLES = 20000;
    localparam int CLK_HALF       = 5;
    localparam int PS2_HALF       = 400;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_break;
    logic       key_ext;
    logic       frame_err;
    logic       rx_busy;

    typedef struct packed {
        logic       is_err;
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    ps2_key_decoder #(
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_break (key_break),
        .key_ext   (key_ext),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #CLK_HALF clk = ~clk;

    // Every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && (key_valid || frame_err)) begin
            n_checks++;
            if (key_valid && frame_err) begin
                $display("FAIL strobe_overlap: key_valid=1 frame_err=1, required at most one");
            end else if (exp_q.size() == 0) begin
                $display("FAIL unexpected_event: key_valid=%0b frame_err=%0b code=%02h, required no event",
                         key_valid, frame_err, key_code);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.is_err) begin
                    if (frame_err) n_pass++;
                    else $display("FAIL event_err: got key_valid code=%02h brk=%0b ext=%0b, required frame_err",
                                  key_code, key_break, key_ext);
                end else if (key_valid && key_code === mon_e.code &&
                             key_break === mon_e.brk && key_ext === mon_e.ext) begin
                    n_pass++;
                end else begin
                    $display("FAIL event_key: got valid=%0b code=%02h brk=%0b ext=%0b, required code=%02h brk=%0b ext=%0b",
                             key_valid, key_code, key_break, key_ext, mon_e.code, mon_e.brk, mon_e.ext);
                end
            end
        end
    end

    task automatic expect_key(input logic [7:0] code, input logic brk, input logic ext);
        exp_t e;
        e.is_err = 1'b0; e.code = code; e.brk = brk; e.ext = ext;
        exp_q.push_back(e);
    endtask

    task automatic expect_err();
        exp_t e;
        e = '0;
        e.is_err = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        #(PS2_HALF);
        ps2_clk = 1'b0;
        #(PS2_HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic bad_par, input logic bad_stop);
        logic par;
        par = ~(^data) ^ bad_par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        send_bit(par);
        send_bit(~bad_stop);
        ps2_data = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (20) @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain_%s: %0d events outstanding, required 0", name, exp_q.size());
        exp_q.delete();
    endtask

    task automatic check_outputs_zero(input string name);
        n_checks++;
        if ({key_valid, key_code, key_break, key_ext, frame_err, rx_busy} === 13'd0) n_pass++;
        else $display("FAIL %s: valid=%0b code=%02h brk=%0b ext=%0b err=%0b busy=%0b, required all 0",
                      name, key_valid, key_code, key_break, key_ext, frame_err, rx_busy);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_state");
        rst = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single();
        expect_key(8'h1D, 1'b0, 1'b0);
        send_frame(8'h1D, 1'b0, 1'b0);
        wait_drain("single");
    endtask

    task automatic test_break();
        expect_key(8'h1D, 1'b1, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1D, 1'b0, 1'b0);
        wait_drain("break");
    endtask

    task automatic test_ext_break();
        expect_key(8'h75, 1'b1, 1'b1);
        expect_key(8'h75, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        wait_drain("ext_break");
    endtask

    task automatic test_parity();
`ifdef PS2_PARITY_CHECK_EN
        expect_err();
`else
        expect_key(8'h29, 1'b0, 1'b0);
`endif
        send_frame(8'h29, 1'b1, 1'b0);
        wait_drain("parity");
    endtask

    task automatic test_bad_stop();
        expect_err();
        expect_key(8'h1D, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h1D, 1'b0, 1'b1);
        send_frame(8'h1D, 1'b0, 1'b0);
        wait_drain("bad_stop");
    endtask

    task automatic test_bad_start();
        send_bit(1'b1);
        repeat (10) @(negedge clk);
        n_checks++;
        if (rx_busy === 1'b0) n_pass++;
        else $display("FAIL bad_start_busy: rx_busy=%0b, required 0", rx_busy);
        expect_key(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0);
        wait_drain("bad_start");
    endtask

    task automatic test_back_to_back();
        expect_key(8'hFA, 1'b0, 1'b0);
        expect_key(8'hAA, 1'b0, 1'b0);
        expect_key(8'hE1, 1'b0, 1'b0);
        expect_key(8'h6B, 1'b0, 1'b1);
        send_frame(8'hFA, 1'b0, 1'b0);
        send_frame(8'hAA, 1'b0, 1'b0);
        send_frame(8'hE1, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h6B, 1'b0, 1'b0);
        wait_drain("back_to_back");
    endtask

    task automatic test_timeout();
        logic [7:0] d;
        int  k;
        bit  seen;
        d = 8'h3C;
        expect_err();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        ps2_data = d[4];
        #(PS2_HALF);
        ps2_clk = 1'b0;
        k = 0;
        seen = 1'b0;
        while (!seen && k < TIMEOUT_CYCLES + 200) begin
            @(negedge clk);
            k++;
            if (k == PS2_HALF / (2 * CLK_HALF)) ps2_clk = 1'b1;
            if (k == 100) begin
                n_checks++;
                if (rx_busy === 1'b1) n_pass++;
                else $display("FAIL timeout_busy_mid: rx_busy=%0b, required 1", rx_busy);
            end
            if (frame_err) seen = 1'b1;
        end
        n_checks++;
        if (seen && k >= TIMEOUT_CYCLES + 2 && k <= TIMEOUT_CYCLES + 4) n_pass++;
        else $display("FAIL timeout_latency: seen=%0b cycles=%0d, required %0d..%0d",
                      seen, k, TIMEOUT_CYCLES + 2, TIMEOUT_CYCLES + 4);
        n_checks++;
        if (rx_busy === 1'b0) n_pass++;
        else $display("FAIL timeout_busy_after: rx_busy=%0b, required 0", rx_busy);
        ps2_data = 1'b1;
        wait_drain("timeout_err");
        expect_key(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0);
        wait_drain("timeout_recover");
    endtask

    task automatic test_reset_midframe();
        send_frame(8'hF0, 1'b0, 1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        n_checks++;
        if (rx_busy === 1'b1 && key_code === 8'h5A) n_pass++;
        else $display("FAIL pre_reset: busy=%0b code=%02h, required busy=1 code=5A", rx_busy, key_code);
        #3;
        rst = 1'b0;
        #1;
        check_outputs_zero("reset_midframe");
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        @(negedge clk);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        expect_key(8'h1B, 1'b0, 1'b0);
        send_frame(8'h1B, 1'b0, 1'b0);
        wait_drain("reset_recover");
    endtask

    initial begin
        #(2ms);
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_break();
        test_ext_break();
        test_parity();
        test_bad_stop();
        test_bad_start();
        test_back_to_back();
        test_timeout();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
